// File: rtl/mem_access_stage_if.sv
// EX/MEM-to-MEM/WB bus for the MEM stage: pipeline inputs, passthroughs, load data and the debug read port.
interface mem_access_stage_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7,
  parameter int NB_REG  = 5,
  parameter int NB_MEM  = 5
);
  logic               enable_pipe_i;
  logic [NB_DATA-1:0] alu_result_i;
  logic [NB_DATA-1:0] write_data_i;
  logic [NB_MEM-1:0]  mem_ctrl_i;
  logic [NB_REG-1:0]  write_register_i;
  logic [2:0]         wb_signals_i;
  logic [6:0]         pc_i;
  logic [NB_ADDR-1:0] debug_addr_i;
  logic [NB_DATA-1:0] mem_data_read_o;
  logic [NB_DATA-1:0] alu_result_o;
  logic [NB_REG-1:0]  write_register_o;
  logic [2:0]         wb_signals_o;
  logic [6:0]         pc_o;
  logic               misaligned_o;
  logic [NB_DATA-1:0] debug_data_o;

  modport master (
    output enable_pipe_i, alu_result_i, write_data_i, mem_ctrl_i, write_register_i,
           wb_signals_i, pc_i, debug_addr_i,
    input  mem_data_read_o, alu_result_o, write_register_o, wb_signals_o, pc_o,
           misaligned_o, debug_data_o
  );

  modport slave (
    input  enable_pipe_i, alu_result_i, write_data_i, mem_ctrl_i, write_register_i,
           wb_signals_i, pc_i, debug_addr_i,
    output mem_data_read_o, alu_result_o, write_register_o, wb_signals_o, pc_o,
           misaligned_o, debug_data_o
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data memory (falling-edge write, async read), byte/half/word lane steering,
// load extension, sticky misalignment flag and a registered debug read port.
module mem_access_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7,
  parameter int NB_REG  = 5,
  parameter int NB_MEM  = 5
) (
  input logic clock_i,
  input logic reset_i,
  mem_access_stage_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic               misaligned_q;
  logic [NB_DATA-1:0] debug_q;

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         offset;
  logic               rd, wr, uns;
  logic [1:0]         size;
  logic               aligned;
  logic               we;
  logic [NB_DATA-1:0] rd_word;
  logic [NB_DATA-1:0] merged_d;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_DATA-1:0] load_d;

  assign word_idx = bus.alu_result_i[NB_ADDR+1:2];
  assign offset   = bus.alu_result_i[1:0];
  assign rd       = bus.mem_ctrl_i[4];
  assign wr       = bus.mem_ctrl_i[3];
  assign uns      = bus.mem_ctrl_i[2];
  assign size     = bus.mem_ctrl_i[1:0];
  assign rd_word  = mem_q[word_idx];
  assign byte_sel = rd_word[{offset, 3'b000} +: 8];
  assign half_sel = rd_word[{offset[1], 4'b0000} +: 16];
  assign we       = bus.enable_pipe_i && wr && aligned;

  always_comb begin
    aligned = 1'b0;
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~offset[0];
      2'b11:   aligned = (offset == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Store merges into the current word so untouched lanes keep their contents.
  always_comb begin
    merged_d = rd_word;
    case (size)
      2'b00:   merged_d[{offset, 3'b000} +: 8]     = bus.write_data_i[7:0];
      2'b01:   merged_d[{offset[1], 4'b0000} +: 16] = bus.write_data_i[15:0];
      default: merged_d = bus.write_data_i;
    endcase
  end

  always_comb begin
    load_d = '0;
    if (rd && aligned) begin
      case (size)
        2'b00:   load_d = uns ? {{(NB_DATA-8){1'b0}}, byte_sel}
                              : {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
        2'b01:   load_d = uns ? {{(NB_DATA-16){1'b0}}, half_sel}
                              : {{(NB_DATA-16){half_sel[15]}}, half_sel};
        default: load_d = rd_word;
      endcase
    end
  end

  always_ff @(negedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      misaligned_q <= 1'b0;
      debug_q      <= '0;
    end else begin
      if (we) mem_q[word_idx] <= merged_d;
      if (bus.enable_pipe_i && (rd || wr) && !aligned) misaligned_q <= 1'b1;
      debug_q <= mem_q[bus.debug_addr_i];
    end
  end

  assign bus.mem_data_read_o  = load_d;
  assign bus.alu_result_o     = bus.alu_result_i;
  assign bus.write_register_o = bus.write_register_i;
  assign bus.wb_signals_o     = bus.wb_signals_i;
  assign bus.pc_o             = bus.pc_i;
  assign bus.misaligned_o     = misaligned_q;
  assign bus.debug_data_o     = debug_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores/loads, lane steering, misalignment, stall, reset, wrap.
module tb_mem_access_stage;
  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_SW   = 5'b01011;
  localparam logic [4:0] C_SH   = 5'b01001;
  localparam logic [4:0] C_SB   = 5'b01000;
  localparam logic [4:0] C_LW   = 5'b10011;
  localparam logic [4:0] C_LH   = 5'b10001;
  localparam logic [4:0] C_LB   = 5'b10000;
  localparam logic [4:0] C_LBU  = 5'b10100;
  localparam logic [4:0] C_RW   = 5'b11011;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #10 clock_i = ~clock_i;

  mem_access_stage_if #(.NB_DATA(32), .NB_ADDR(7), .NB_REG(5), .NB_MEM(5)) bus ();

  mem_access_stage #(.NB_DATA(32), .NB_ADDR(7), .NB_REG(5), .NB_MEM(5)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  task automatic drive(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
    bus.mem_ctrl_i   = ctrl;
    bus.alu_result_i = addr;
    bus.write_data_i = data;
  endtask

  // One store through a falling edge, then the bus goes idle again.
  task automatic store_op(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clock_i); #1;
    drive(ctrl, addr, data);
    @(negedge clock_i); #1;
    drive(C_IDLE, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    bus.enable_pipe_i = 1'b1;
    bus.write_register_i = 5'd17;
    bus.wb_signals_i = 3'b101;
    bus.pc_i = 7'h2A;
    bus.debug_addr_i = 7'd4;
    drive(C_LW, 32'h10, 32'h0);
    #3;
    n_cmp++; if (bus.misaligned_o !== 1'b0) begin n_err++; $display("FAIL reset_misaligned got=%0b exp=0", bus.misaligned_o); end
    n_cmp++; if (bus.debug_data_o !== 32'h0) begin n_err++; $display("FAIL reset_debug got=%h exp=0", bus.debug_data_o); end
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL reset_load got=%h exp=0", bus.mem_data_read_o); end
    n_cmp++; if (bus.alu_result_o !== 32'h10 || bus.write_register_o !== 5'd17 || bus.wb_signals_o !== 3'b101 || bus.pc_o !== 7'h2A) begin
      n_err++; $display("FAIL reset_passthru got=%h/%0d/%b/%h exp=00000010/17/101/2a",
                        bus.alu_result_o, bus.write_register_o, bus.wb_signals_o, bus.pc_o);
    end
    drive(C_IDLE, 32'h0, 32'h0);
    @(posedge clock_i); #2;
    reset_i = 1'b1;
  endtask

  task automatic test_word;
    store_op(C_SW, 32'h10, 32'hDEADBEEF);
    drive(C_LW, 32'h10, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_10 got=%h exp=deadbeef", bus.mem_data_read_o); end
    drive(C_IDLE, 32'h0, 32'h0);
    bus.debug_addr_i = 7'd4;
    @(negedge clock_i); #1;
    n_cmp++; if (bus.debug_data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL debug_w4 got=%h exp=deadbeef", bus.debug_data_o); end
  endtask

  task automatic test_subword;
    store_op(C_SB, 32'h11, 32'hFFFFFF80);
    drive(C_LW, 32'h10, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'hDEAD80EF) begin n_err++; $display("FAIL sb_merge got=%h exp=dead80ef", bus.mem_data_read_o); end
    drive(C_LB, 32'h11, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_11 got=%h exp=ffffff80", bus.mem_data_read_o); end
    drive(C_LBU, 32'h11, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h00000080) begin n_err++; $display("FAIL lbu_11 got=%h exp=00000080", bus.mem_data_read_o); end
    drive(C_LH, 32'h12, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'hFFFFDEAD) begin n_err++; $display("FAIL lh_12 got=%h exp=ffffdead", bus.mem_data_read_o); end
    drive(5'b10101, 32'h10, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h000080EF) begin n_err++; $display("FAIL lhu_10 got=%h exp=000080ef", bus.mem_data_read_o); end
    drive(C_IDLE, 32'h0, 32'h0);
  endtask

  task automatic test_stall;
    bus.debug_addr_i = 7'h0C;
    @(posedge clock_i); #1;
    bus.enable_pipe_i = 1'b0;
    drive(C_SW, 32'h30, 32'h55);
    @(negedge clock_i); #1;
    n_cmp++; if (bus.debug_data_o !== 32'h0) begin n_err++; $display("FAIL stall_nowrite got=%h exp=0", bus.debug_data_o); end
    drive(C_SH, 32'h21, 32'h1234);
    @(negedge clock_i); #1;
    n_cmp++; if (bus.misaligned_o !== 1'b0) begin n_err++; $display("FAIL stall_misaligned got=%0b exp=0", bus.misaligned_o); end
    drive(C_SW, 32'h30, 32'h55);
    bus.enable_pipe_i = 1'b1;
    @(negedge clock_i); #1;
    drive(C_IDLE, 32'h0, 32'h0);
    n_cmp++; if (bus.debug_data_o !== 32'h0) begin n_err++; $display("FAIL debug_same_edge got=%h exp=0", bus.debug_data_o); end
    @(negedge clock_i); #1;
    n_cmp++; if (bus.debug_data_o !== 32'h55) begin n_err++; $display("FAIL stall_release got=%h exp=00000055", bus.debug_data_o); end
  endtask

  task automatic test_misaligned;
    store_op(C_SH, 32'h21, 32'h1234);
    drive(C_LW, 32'h20, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL sh_mis_nowrite got=%h exp=0", bus.mem_data_read_o); end
    drive(C_LH, 32'h13, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL lh_mis_load got=%h exp=0", bus.mem_data_read_o); end
    drive(5'b10010, 32'h10, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL size10_load got=%h exp=0", bus.mem_data_read_o); end
    drive(C_IDLE, 32'h0, 32'h0);
    n_cmp++; if (bus.misaligned_o !== 1'b1) begin n_err++; $display("FAIL misaligned_set got=%0b exp=1", bus.misaligned_o); end
    repeat (10) @(negedge clock_i);
    #1;
    n_cmp++; if (bus.misaligned_o !== 1'b1) begin n_err++; $display("FAIL misaligned_sticky got=%0b exp=1", bus.misaligned_o); end
  endtask

  task automatic test_reset_mid;
    @(posedge clock_i); #3;
    reset_i = 1'b0;
    #1;
    n_cmp++; if (bus.misaligned_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_misaligned got=%0b exp=0", bus.misaligned_o); end
    n_cmp++; if (bus.debug_data_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_debug got=%h exp=0", bus.debug_data_o); end
    drive(C_LW, 32'h10, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_lw10 got=%h exp=0", bus.mem_data_read_o); end
    drive(C_LW, 32'h30, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_lw30 got=%h exp=0", bus.mem_data_read_o); end
    drive(C_IDLE, 32'h0, 32'h0);
    @(posedge clock_i); #2;
    reset_i = 1'b1;
  endtask

  task automatic test_wrap_and_rw;
    store_op(C_SW, 32'h200, 32'hA5A5A5A5);
    drive(C_LW, 32'h0, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wrap_lw0 got=%h exp=a5a5a5a5", bus.mem_data_read_o); end
    drive(C_LW, 32'h4, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL wrap_lw4 got=%h exp=0", bus.mem_data_read_o); end
    @(posedge clock_i); #1;
    drive(C_RW, 32'h40, 32'h11112222); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h0) begin n_err++; $display("FAIL rw_preload got=%h exp=0", bus.mem_data_read_o); end
    @(negedge clock_i); #1;
    drive(C_LW, 32'h40, 32'h0); #1;
    n_cmp++; if (bus.mem_data_read_o !== 32'h11112222) begin n_err++; $display("FAIL rw_stored got=%h exp=11112222", bus.mem_data_read_o); end
    drive(C_IDLE, 32'h0, 32'h0);
  endtask

  initial begin
    bus.enable_pipe_i = 1'b0;
    bus.write_register_i = '0;
    bus.wb_signals_i = '0;
    bus.pc_i = '0;
    bus.debug_addr_i = '0;
    drive(C_IDLE, 32'h0, 32'h0);
    test_reset;
    test_word;
    test_subword;
    test_stall;
    test_misaligned;
    test_reset_mid;
    test_wrap_and_rw;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
